// File: rtl/crypt_pkg.sv
// Shared constants and slot metadata for the DES iteration controller.
// The slot record travels round the metadata ring in lock-step with its data.
package crypt_pkg;

  localparam int PIPE_LAT   = 16;
  localparam int ITERS      = 25;
  localparam int CNT_W      = 5;
  localparam int KEY_W      = 68;
  localparam int BLK_W      = 32;
  localparam int SLOT_TAG_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [CNT_W-1:0]      count;
    logic [SLOT_TAG_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/crypt_slot_ring.sv
// Metadata shift register, one entry per loop slot. The oldest entry ("ret")
// describes the pipeline outputs in the current cycle.
module crypt_slot_ring
  import crypt_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT + 1
) (
  input  logic  CLK,
  input  logic  RST,
  input  slot_t slot_in,
  output slot_t slot_ret
);

  slot_t ring_q [DEPTH];
  slot_t ring_d [DEPTH];

  always_comb begin
    ring_d[0] = slot_in;
    for (int i = 1; i < DEPTH; i++) begin
      ring_d[i] = ring_q[i-1];
    end
  end

  // NOTE: this array is cleared on reset because its valid bits decide whether
  // stale pipeline data is ever reported; data-only storage would not need it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      ring_q <= ring_d;
    end
  end

  assign slot_ret = ring_q[DEPTH-1];

endmodule

// File: rtl/crypt_iter_ctrl.sv
// Drives the 16-stage salted DES pipeline: injects candidates into free loop
// slots, recirculates each for ITERS passes, then reports the final L/R with its tag.
module crypt_iter_ctrl
  import crypt_pkg::slot_t, crypt_pkg::CNT_W, crypt_pkg::KEY_W,
         crypt_pkg::BLK_W, crypt_pkg::SLOT_TAG_W;
#(
  parameter int PIPE_LAT = crypt_pkg::PIPE_LAT,
  parameter int ITERS    = crypt_pkg::ITERS,
  parameter int TAG_W    = crypt_pkg::SLOT_TAG_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic [BLK_W-1:0] p_L,
  output logic [BLK_W-1:0] p_R,
  output logic [KEY_W-1:0] p_K,
  input  logic [BLK_W-1:0] p_L_ret,
  input  logic [BLK_W-1:0] p_R_ret,
  input  logic [KEY_W-1:0] p_K_ret,
  output logic             out_valid,
  output logic [BLK_W-1:0] out_L,
  output logic [BLK_W-1:0] out_R,
  output logic [TAG_W-1:0] out_tag
);

  // The input register closes the loop, so one lap is the pipeline plus one.
  localparam int DEPTH = PIPE_LAT + 1;

  slot_t slot_ret;
  slot_t slot_in;
  logic  finish;
  logic  recirc;

  logic [BLK_W-1:0] p_L_q,     p_L_d;
  logic [BLK_W-1:0] p_R_q,     p_R_d;
  logic [KEY_W-1:0] p_K_q,     p_K_d;
  logic             out_valid_q, out_valid_d;
  logic [BLK_W-1:0] out_L_q,   out_L_d;
  logic [BLK_W-1:0] out_R_q,   out_R_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  crypt_slot_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .CLK      (CLK),
    .RST      (RST),
    .slot_in  (slot_in),
    .slot_ret (slot_ret)
  );

  // A finishing slot is free on the same edge, so only recirculation blocks input.
  always_comb begin
    finish   = slot_ret.valid && (slot_ret.count == CNT_W'(ITERS - 1));
    recirc   = slot_ret.valid && !finish;
    in_ready = !recirc;
  end

  always_comb begin
    // NOTE: each signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    slot_in     = '0;
    p_L_d       = p_L_q;
    p_R_d       = p_R_q;
    p_K_d       = p_K_q;
    out_valid_d = finish;
    out_L_d     = out_L_q;
    out_R_d     = out_R_q;
    out_tag_d   = out_tag_q;

    if (finish) begin
      out_L_d   = p_L_ret;
      out_R_d   = p_R_ret;
      out_tag_d = TAG_W'(slot_ret.tag);
    end

    if (recirc) begin
      slot_in.valid = 1'b1;
      slot_in.count = slot_ret.count + CNT_W'(1);
      slot_in.tag   = slot_ret.tag;
      p_L_d         = p_L_ret;
      p_R_d         = p_R_ret;
      p_K_d         = p_K_ret;
    end else if (in_valid) begin
      slot_in.valid = 1'b1;
      slot_in.count = '0;
      slot_in.tag   = SLOT_TAG_W'(in_tag);
      p_L_d         = '0;
      p_R_d         = '0;
      p_K_d         = in_key;
    end
    // A bubble leaves p_* holding their old value; the slot is marked empty.
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_L_q       <= '0;
      p_R_q       <= '0;
      p_K_q       <= '0;
      out_valid_q <= 1'b0;
      out_L_q     <= '0;
      out_R_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      p_L_q       <= p_L_d;
      p_R_q       <= p_R_d;
      p_K_q       <= p_K_d;
      out_valid_q <= out_valid_d;
      out_L_q     <= out_L_d;
      out_R_q     <= out_R_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign p_L       = p_L_q;
  assign p_R       = p_R_q;
  assign p_K       = p_K_q;
  assign out_valid = out_valid_q;
  assign out_L     = out_L_q;
  assign out_R     = out_R_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_crypt_iter_ctrl.sv
// Bench for crypt_iter_ctrl with a stand-in 16-stage pipeline and a
// candidate-level scoreboard that predicts readiness, loop contents and results.
module tb_crypt_iter_ctrl;

  localparam int D     = 17;
  localparam int ITERS = 25;
  localparam int LAT   = ITERS * D;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [67:0] in_key = '0;
  logic [15:0] in_tag = '0;
  logic [31:0] p_L, p_R, p_L_ret, p_R_ret;
  logic [67:0] p_K, p_K_ret;
  logic        out_valid;
  logic [31:0] out_L, out_R;
  logic [15:0] out_tag;

  crypt_iter_ctrl dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_tag(in_tag), .p_L(p_L), .p_R(p_R), .p_K(p_K),
    .p_L_ret(p_L_ret), .p_R_ret(p_R_ret), .p_K_ret(p_K_ret),
    .out_valid(out_valid), .out_L(out_L), .out_R(out_R), .out_tag(out_tag)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Stand-in DES pass: a bijective Feistel-like mix; the key returns unchanged,
  // as the real key schedule's 28 rotations per pass restore K.
  function automatic logic [63:0] f_pass(input logic [31:0] l, input logic [31:0] r,
                                         input logic [67:0] k);
    logic [31:0] rot;
    rot = {r[26:0], r[31:27]};
    return {r, l ^ (rot + k[31:0] + 32'h9E3779B9)};
  endfunction

  function automatic logic [63:0] run_iters(input logic [67:0] k, input int n);
    logic [63:0] lr;
    lr = '0;
    for (int i = 0; i < n; i++) lr = f_pass(lr[63:32], lr[31:0], k);
    return lr;
  endfunction

  // Pipeline model: 16 register stages from p_* to p_*_ret.
  logic [31:0] pl [16];
  logic [31:0] pr [16];
  logic [67:0] pk [16];
  initial for (int i = 0; i < 16; i++) begin pl[i] = '0; pr[i] = '0; pk[i] = '0; end

  always @(posedge CLK) begin
    logic [63:0] t;
    t = f_pass(p_L, p_R, p_K);
    pl[0] <= t[63:32];
    pr[0] <= t[31:0];
    pk[0] <= p_K;
    for (int i = 1; i < 16; i++) begin
      pl[i] <= pl[i-1];
      pr[i] <= pr[i-1];
      pk[i] <= pk[i-1];
    end
  end

  assign p_L_ret = pl[15];
  assign p_R_ret = pr[15];
  assign p_K_ret = pk[15];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: a list of in-flight candidates with their accept edge. A slot is
  // busy on edge e when e-acc is a multiple of D below LAT; it finishes at LAT.
  typedef struct {
    logic [15:0] tag;
    logic [67:0] key;
    int          acc;
  } cand_t;

  cand_t       cands[$];
  int          ecnt = 0;
  bit          live = 0;
  logic        exp_ov = 0;
  logic [31:0] exp_oL = '0, exp_oR = '0;
  logic [15:0] exp_otag = '0;
  bit          exp_p_chk = 0;
  logic [31:0] exp_pL = '0, exp_pR = '0;
  logic [67:0] exp_pK = '0;

  always @(negedge CLK) begin
    bit          busy;
    int          fin, d;
    logic [63:0] lr;
    if (live) begin
      check("out_valid", out_valid, exp_ov);
      check("out_L", out_L, exp_oL);
      check("out_R", out_R, exp_oR);
      check("out_tag", out_tag, exp_otag);
      if (exp_p_chk) begin
        check("p_L", p_L, exp_pL);
        check("p_R", p_R, exp_pR);
        check("p_K", p_K, exp_pK);
      end
    end
    ecnt++;
    busy = 0;
    foreach (cands[i]) begin
      d = ecnt - cands[i].acc;
      if (d % D == 0 && d < LAT) busy = 1;
    end
    if (live) check("in_ready", in_ready, !busy);
    exp_ov    = 0;
    exp_p_chk = 0;
    if (RST) begin
      cands.delete();
      exp_oL = '0; exp_oR = '0; exp_otag = '0;
      exp_p_chk = 1; exp_pL = '0; exp_pR = '0; exp_pK = '0;
      live = 1;
    end else begin
      fin = -1;
      foreach (cands[i]) if (ecnt - cands[i].acc == LAT) fin = i;
      if (fin >= 0) begin
        lr       = run_iters(cands[fin].key, ITERS);
        exp_oL   = lr[63:32];
        exp_oR   = lr[31:0];
        exp_otag = cands[fin].tag;
        exp_ov   = 1;
        cands.delete(fin);
      end
      if (!busy && in_valid) cands.push_back('{in_tag, in_key, ecnt});
      foreach (cands[i]) begin
        d = ecnt - cands[i].acc;
        if (d % D == 0) begin
          lr        = run_iters(cands[i].key, d / D);
          exp_p_chk = 1;
          exp_pL    = lr[63:32];
          exp_pR    = lr[31:0];
          exp_pK    = cands[i].key;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic offer(input logic [15:0] tag, input logic [67:0] key, output int acc);
    bit took;
    int waited;
    took = 0;
    waited = 0;
    in_valid = 1'b1;
    in_tag   = tag;
    in_key   = key;
    while (!took && waited < 600) begin
      @(negedge CLK);
      took = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    acc = cyc;
    check("offer_accepted", took, 1'b1);
  endtask

  function automatic logic [67:0] key_of(input int t);
    return {4'h0, 32'(t * 32'h01234567), 32'(t) ^ 32'hA5A5A5A5};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc [64];
    int          a0, cnt, at;
    logic [15:0] tag_at;
    logic [67:0] kb;
    logic [63:0] lr;

    // Pin the reference function with hand-computed passes.
    check("pin_iter1", run_iters(68'h0, 1), {32'h0, 32'h9E3779B9});
    check("pin_iter2", run_iters(68'h0, 2), {32'h9E3779B9, 32'h6526B0EC});

    // Reset state.
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_L", out_L, 32'h0);
    check("rst_p_K", p_K, 68'h0);
    tick();

    // Single candidate: one strobe, 425 edges after accept.
    offer(16'h0003, 68'h0, a0);
    cnt = 0; at = -1; tag_at = '0;
    for (int i = 0; i <= 440; i++) begin
      @(negedge CLK);
      if (out_valid) begin cnt++; at = i; tag_at = out_tag; end
    end
    tick();
    check("single_strobes", cnt, 1);
    check("single_at", at, 425);
    check("single_tag", tag_at, 16'h0003);

    // Fill: tags 0..40 offered back to back.
    for (int t = 0; t <= 40; t++) offer(16'(t), key_of(t), acc[t]);
    check("fill_acc16", acc[16] - acc[0], 16);
    check("fill_acc17", acc[17] - acc[0], 425);
    check("fill_acc33", acc[33] - acc[0], 441);
    check("fill_acc34", acc[34] - acc[0], 850);
    repeat (440) tick();

    // Bubbles: candidates only on even edges 0..16.
    for (int e = 0; e <= 16; e++) begin
      in_valid = (e % 2 == 0);
      in_tag   = 16'(100 + e);
      in_key   = key_of(100 + e);
      tick();
    end
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      if (in_ready) cnt++;
    end
    tick();
    check("bubble_free_slots", cnt, 8);
    cnt = 0;
    for (int i = 0; i < 430; i++) begin
      @(negedge CLK);
      if (out_valid) cnt++;
    end
    tick();
    check("bubble_results", cnt, 9);

    // Handshake hold: full ring, then 0xBEEF waits for a free slot.
    for (int t = 0; t < 17; t++) offer(16'(200 + t), key_of(200 + t), acc[t]);
    kb = 68'h5_1234_5678_9ABC_DEF0;
    offer(16'hBEEF, kb, at);
    check("hold_acc", at - acc[0], 425);
    cnt = 0;
    tag_at = '0;
    lr = run_iters(kb, ITERS);
    for (int i = 0; i < 500 && cnt == 0; i++) begin
      @(negedge CLK);
      if (out_valid && out_tag == 16'hBEEF) begin
        cnt = 1;
        check("hold_out_L", out_L, lr[63:32]);
      end
    end
    tick();
    check("hold_seen", cnt, 1);
    repeat (20) tick();

    // Key recirculation with salt 0xFFF: p_K equals in_key on every lap.
    kb = {$urandom(), 24'($urandom()), 12'hFFF};
    offer(16'h0777, kb, a0);
    @(negedge CLK);
    check("lap_pK_0", p_K, kb);
    for (int n = 1; n < ITERS; n++) begin
      repeat (17) @(negedge CLK);
      check("lap_pK", p_K, kb);
    end
    tick();
    repeat (440) tick();

    // Reset mid-run drops everything.
    for (int t = 0; t < 17; t++) offer(16'(300 + t), key_of(300 + t), acc[t]);
    repeat (183) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_L", out_L, 32'h0);
    check("midrst_out_tag", out_tag, 16'h0);
    check("midrst_p_L", p_L, 32'h0);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (out_valid) cnt++;
    end
    check("midrst_no_strobe", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
